alu_seq: RTL and testbench

//  Parametrised, registered successor to the 16-function combinational ALU.

---
 rtl/alu_seq.sv | 207 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with iterative shifts and an optional iterative multiply, behind a
// valid/ready handshake. Only one operation is in flight at a time.
//
// Configuration macro: ALU_MUL_EN. When it is defined, card 19 is an unsigned shift-add multiply.
// When it is undefined, card 19 is reserved and raises err.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   in_valid, in_ready  request handshake; a/b/cin/card are sampled only on the accept edge
//   a, b                operands (the shift amount is b[SHAMT_W-1:0])
//   cin                 carry/borrow in
//   card                operation select (0-15 logic/arith, 16-18 shifts, 19 MUL, 20-31 reserved)
//   out_valid/out_ready result handshake
//   f, cout, zero, err  result, carry/no-borrow/MUL-high-nonzero, f==0, reserved-op flag
module alu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [4:0]       card,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             cout,
   output logic             zero,
   output logic             err
);

   localparam int unsigned SHAMT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
   // Shift encodings match card[1:0] for cards 16..18.
   typedef enum logic [1:0] {OpSll, OpSrl, OpSra, OpMul} op_e;

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]   f_q, f_d;
   logic               cout_q, cout_d;
   logic               zero_q, zero_d;
   logic               err_q, err_d;

`ifdef ALU_MUL_EN
   // prod_q: upper half accumulates partial products, lower half holds the remaining multiplier.
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH:0]     pp_sum;
`endif

   logic               accept;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   add_x, add_y;
   logic               add_c;
   logic [WIDTH:0]     arith;
   logic [WIDTH-1:0]   sc_f;
   logic               sc_cout;
   logic               sc_err;

   assign shamt    = b[SHAMT_W-1:0];
   assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
   assign accept   = in_valid && in_ready;

   // Single-cycle result. Subtracts use x + ~y + !borrow so cout reads as "no borrow".
   always_comb begin
      add_x   = a;
      add_y   = b;
      add_c   = 1'b0;
      sc_f    = '0;
      sc_cout = 1'b0;
      sc_err  = 1'b0;
      case (card)
         5'd1:    add_c = cin;
         5'd2:    begin add_y = ~b; add_c = 1'b1; end
         5'd3:    begin add_y = ~b; add_c = ~cin; end
         5'd4:    begin add_x = b; add_y = ~a; add_c = 1'b1; end
         5'd5:    begin add_x = b; add_y = ~a; add_c = ~cin; end
         default: ;
      endcase
      arith = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_c};
      case (card)
         5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5: begin
            sc_f    = arith[WIDTH-1:0];
            sc_cout = arith[WIDTH];
         end
         5'd6:  sc_f = a;
         5'd7:  sc_f = b;
         5'd8:  sc_f = ~a;
         5'd9:  sc_f = ~b;
         5'd10: sc_f = a | b;
         5'd11: sc_f = a & b;
         5'd12: sc_f = ~(a ^ b);
         5'd13: sc_f = a ^ b;
         5'd14: sc_f = ~(a & b);
         5'd15: sc_f = '0;
         // Zero-distance shifts finish immediately with f = a.
         5'd16, 5'd17, 5'd18: sc_f = a;
`ifdef ALU_MUL_EN
         5'd19: sc_f = '0;
`endif
         default: sc_err = 1'b1;
      endcase
   end

`ifdef ALU_MUL_EN
   assign pp_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                   (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      f_d     = f_q;
      cout_d  = cout_q;
      zero_d  = zero_q;
      err_d   = err_q;
`ifdef ALU_MUL_EN
      prod_d  = prod_q;
      mcand_d = mcand_q;
`endif
      if (accept) begin
         f_d     = sc_f;
         cout_d  = sc_cout;
         err_d   = sc_err;
         zero_d  = (sc_f == '0);
         state_d = StDone;
         // Counter runs shamt-1 .. 0, one shift per BUSY cycle.
         cnt_d   = shamt - SHAMT_W'(1);
         if ((card inside {5'd16, 5'd17, 5'd18}) && (shamt != '0)) begin
            state_d = StBusy;
            op_d    = op_e'(card[1:0]);
         end
`ifdef ALU_MUL_EN
         if (card == 5'd19) begin
            state_d = StBusy;
            op_d    = OpMul;
            cnt_d   = SHAMT_W'(WIDTH - 1);
            prod_d  = {{WIDTH{1'b0}}, b};
            mcand_d = a;
         end
`endif
      end else begin
         unique case (state_q)
            StBusy: begin
               case (op_q)
                  OpSll: f_d = f_q << 1;
                  OpSrl: f_d = f_q >> 1;
                  OpSra: f_d = {f_q[WIDTH-1], f_q[WIDTH-1:1]};
`ifdef ALU_MUL_EN
                  OpMul: begin
                     prod_d = {pp_sum, prod_q[WIDTH-1:1]};
                     f_d    = prod_d[WIDTH-1:0];
                     cout_d = |prod_d[2*WIDTH-1:WIDTH];
                  end
`endif
                  default: ;
               endcase
               zero_d = (f_d == '0);
               cnt_d  = cnt_q - SHAMT_W'(1);
               if (cnt_q == '0) state_d = StDone;
            end
            StDone:  if (out_ready) state_d = StIdle;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         op_q    <= OpSll;
         cnt_q   <= '0;
         f_q     <= '0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef ALU_MUL_EN
         prod_q  <= '0;
         mcand_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         f_q     <= f_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
         err_q   <= err_d;
`ifdef ALU_MUL_EN
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
`endif
      end
   end

   assign out_valid = (state_q == StDone);
   assign f         = f_q;
   assign cout      = cout_q;
   assign zero      = zero_q;
   assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed vectors, handshake scenarios and
// randomized operations checked against a behavioural arithmetic model.
module tb_alu_seq;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          cin = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [4:0]    card = '0;
   logic          in_ready, out_valid, cout, zero, err;
   logic [W-1:0]  f;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .card      (card),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .f         (f),
      .cout      (cout),
      .zero      (zero),
      .err       (err)
   );

   // Reference model: plain arithmetic on wide integers.
   task automatic model(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y,
                        input logic ci, output logic [31:0] ef, output logic ec,
                        output logic ee, output int lat);
      longint unsigned lx, ly, p;
      int sh;
      lx = 64'(x);
      ly = 64'(y);
      ef = '0; ec = 1'b0; ee = 1'b0; lat = 1;
      sh = int'(y[4:0]);
      case (c)
         5'd0: begin p = lx + ly; ef = p[31:0]; ec = p[32]; end
         5'd1: begin p = lx + ly + 64'(ci); ef = p[31:0]; ec = p[32]; end
         5'd2: begin ef = x - y; ec = (lx >= ly); end
         5'd3: begin ef = x - y - 32'(ci); ec = (lx >= ly + 64'(ci)); end
         5'd4: begin ef = y - x; ec = (ly >= lx); end
         5'd5: begin ef = y - x - 32'(ci); ec = (ly >= lx + 64'(ci)); end
         5'd6: ef = x;
         5'd7: ef = y;
         5'd8: ef = ~x;
         5'd9: ef = ~y;
         5'd10: ef = x | y;
         5'd11: ef = x & y;
         5'd12: ef = ~(x ^ y);
         5'd13: ef = x ^ y;
         5'd14: ef = ~(x & y);
         5'd15: ef = '0;
         5'd16: begin ef = x << sh; lat = 1 + sh; end
         5'd17: begin ef = x >> sh; lat = 1 + sh; end
         5'd18: begin ef = $unsigned($signed(x) >>> sh); lat = 1 + sh; end
`ifdef ALU_MUL_EN
         5'd19: begin p = lx * ly; ef = p[31:0]; ec = (p[63:32] != 0); lat = 1 + W; end
`endif
         default: ee = 1'b1;
      endcase
   endtask

   // Issue one op from IDLE, scramble inputs after accept, wait (bounded) for the result,
   // then consume it. lat counts accept cycle as 1.
   task automatic run_op(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y,
                         input logic ci, output int lat, output logic [31:0] of,
                         output logic oc, output logic oz, output logic oe,
                         output bit ready_busy);
      card = c; a = x; b = y; cin = ci; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; card = 5'($urandom); cin = 1'($urandom);
      lat = 1;
      ready_busy = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) ready_busy = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      of = f; oc = cout; oz = zero; oe = err;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || f !== '0 || cout !== 1'b0 || zero !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got ov=%b f=%h c=%b z=%b e=%b want all 0",
                  out_valid, f, cout, zero, err);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_idle: got ov=%b ir=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_directed();
      int lat;
      logic [31:0] of, ef;
      logic oc, oz, oe, ec, ee;
      int el;
      bit rb;
      // ADD overflow to zero
      run_op(5'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, lat, of, oc, oz, oe, rb);
      checks++;
      if (of !== 32'h0 || oc !== 1'b1 || oz !== 1'b1 || oe !== 1'b0 || lat != 1) begin
         errors++;
         $display("FAIL add_wrap: got f=%h c=%b z=%b e=%b lat=%0d want f=0 c=1 z=1 e=0 lat=1",
                  of, oc, oz, oe, lat);
      end
      // SRA by 4
      run_op(5'd18, 32'h8000_0000, 32'h4, 1'b0, lat, of, oc, oz, oe, rb);
      checks++;
      if (of !== 32'hF800_0000 || oc !== 1'b0 || oz !== 1'b0 || lat != 5) begin
         errors++;
         $display("FAIL sra4: got f=%h c=%b z=%b lat=%0d want f=f8000000 c=0 z=0 lat=5",
                  of, oc, oz, lat);
      end
      checks++;
      if (rb !== 1'b0) begin
         errors++;
         $display("FAIL sra4_in_ready_busy: got in_ready high during BUSY want low");
      end
      // MUL (or reserved without the multiplier)
      run_op(5'd19, 32'h0001_0000, 32'h0001_0000, 1'b0, lat, of, oc, oz, oe, rb);
      model(5'd19, 32'h0001_0000, 32'h0001_0000, 1'b0, ef, ec, ee, el);
      checks++;
      if (of !== ef || oc !== ec || oz !== 1'b1 || oe !== ee || lat != el) begin
         errors++;
         $display("FAIL mul: got f=%h c=%b z=%b e=%b lat=%0d want f=%h c=%b z=1 e=%b lat=%0d",
                  of, oc, oz, oe, lat, ef, ec, ee, el);
      end
   endtask

   task automatic test_back_to_back();
      card = 5'd2; a = 32'd5; b = 32'd7; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || f !== 32'hFFFF_FFFE || cout !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_sub: got ov=%b f=%h c=%b ir=%b want 1 fffffffe 0 1",
                  out_valid, f, cout, in_ready);
      end
      card = 5'd4;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || f !== 32'h2 || cout !== 1'b1) begin
         errors++;
         $display("FAIL b2b_rsub: got ov=%b f=%h c=%b want 1 00000002 1", out_valid, f, cout);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: got ov=%b want 0", out_valid);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_hold();
      logic [31:0] x, y, ef;
      x = $urandom; y = $urandom;
      ef = x ^ y;
      card = 5'd13; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; a = ~x; b = x; card = 5'd0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b1 || f !== ef || zero !== (ef == 0) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold[%0d]: got ov=%b f=%h z=%b ir=%b want 1 %h %b 0",
                     i, out_valid, f, zero, in_ready, ef, (ef == 0));
         end
         @(posedge clk); #1;
      end
      card = 5'd0; a = 32'd1; b = 32'd2; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_release_ready: got %b want 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || f !== 32'd3 || cout !== 1'b0) begin
         errors++;
         $display("FAIL hold_next_op: got ov=%b f=%h c=%b want 1 00000003 0", out_valid, f, cout);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [31:0] of;
      logic oc, oz, oe;
      bit rb, stray;
      card = 5'd16; a = $urandom | 32'h1; b = 32'd20; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || f !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_async: got ov=%b f=%h ir=%b want 0 0 1", out_valid, f, in_ready);
      end
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      stray = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (out_valid !== 1'b0 || in_ready !== 1'b1) stray = 1'b1;
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      checks++;
      if (stray !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_stray: got result or not ready after reset want idle");
      end
      run_op(5'd1, 32'h7FFF_FFFF, 32'h0, 1'b1, lat, of, oc, oz, oe, rb);
      checks++;
      if (of !== 32'h8000_0000 || oc !== 1'b0 || lat != 1) begin
         errors++;
         $display("FAIL reset_mid_recover: got f=%h c=%b lat=%0d want 80000000 0 1", of, oc, lat);
      end
   endtask

   task automatic test_random();
      int lat, el;
      logic [31:0] of, ef, x, y;
      logic oc, oz, oe, ec, ee, ci;
      logic [4:0] c;
      bit rb;
      for (int i = 0; i < 60; i++) begin
         c = 5'($urandom_range(0, 31));
         x = $urandom; y = $urandom; ci = 1'($urandom);
         if (i % 7 == 0) y = x;
         if (i % 11 == 0) y[4:0] = 5'd0;
         model(c, x, y, ci, ef, ec, ee, el);
         run_op(c, x, y, ci, lat, of, oc, oz, oe, rb);
         checks++;
         if (of !== ef || oc !== ec || oz !== (ef == 0) || oe !== ee) begin
            errors++;
            $display("FAIL rand[%0d] card=%0d a=%h b=%h cin=%b: got f=%h c=%b z=%b e=%b want f=%h c=%b z=%b e=%b",
                     i, c, x, y, ci, of, oc, oz, oe, ef, ec, (ef == 0), ee);
         end
         checks++;
         if (lat != el || rb !== 1'b0) begin
            errors++;
            $display("FAIL rand_lat[%0d] card=%0d: got lat=%0d busy_ready=%b want lat=%0d busy_ready=0",
                     i, c, lat, rb, el);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_hold();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
